// File: rtl/pcm_output_stage_if.sv
// Sample-path bundle between the synthesis core (master) and the PCM output stage (slave).
// Carries raw PCM and level controls in, and the decimated, gain-ramped sample out.
interface pcm_output_stage_if;
   logic signed [15:0] pcm_in;
   logic               mute;
   logic               low_batt;
   logic signed [15:0] audio_out;
   logic               sample_stb;
   logic               active;

   modport master (
      output pcm_in, mute, low_batt,
      input  audio_out, sample_stb, active
   );

   modport slave (
      input  pcm_in, mute, low_batt,
      output audio_out, sample_stb, active
   );
endinterface

// File: rtl/pcm_output_stage.sv
// Audio back-end: boxcar-decimates CLK_50M-rate PCM to SAMPLE_HZ, applies a click-free
// per-sample gain ramp (mute / low battery) and publishes a registered sample with a strobe.
module pcm_output_stage #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int SAMPLE_HZ = 48_000,
   parameter int SUM_SHIFT = 10
) (
   input  logic               clk,
   input  logic               reset,
   pcm_output_stage_if.slave  bus
);

   localparam logic [27:0] CLK_C  = 28'(CLK_HZ);
   localparam logic [27:0] STEP_C = 28'(SAMPLE_HZ);

   logic        [26:0] acc_p0;
   logic        [27:0] acc_sum;
   logic               tick_p0;
   logic signed [27:0] sum_p0;
   logic signed [27:0] pcm_ext;
   logic signed [27:0] sum_nxt;
   logic         [8:0] target;
   logic         [8:0] gain_nxt;

   logic signed [15:0] avg_p1;
   logic         [8:0] gain_p1;
   logic               active_p1;
   logic               vld_p1;

   logic signed [15:0] audio_p2;
   logic               vld_p2;

   // Floor-shift the boxcar sum, then clamp so a full-scale input cannot wrap.
   function automatic logic signed [15:0] sat16(input logic signed [27:0] v);
      logic signed [27:0] s;
      s = v >>> SUM_SHIFT;
      if (s > 28'sd32767)
         return 16'sh7fff;
      else if (s < -28'sd32768)
         return 16'sh8000;
      else
         return 16'(s);
   endfunction

   // Gain is at most 256, so the >>>8 result always fits 16 bits.
   function automatic logic signed [15:0] scale(input logic signed [15:0] a,
                                                input logic        [8:0]  g);
      logic signed [25:0] p;
      p = 26'(a) * 26'($signed({1'b0, g}));
      p = p >>> 8;
      return 16'(p);
   endfunction

   always_comb begin
      acc_sum  = {1'b0, acc_p0} + STEP_C;
      tick_p0  = (acc_sum >= CLK_C);
      pcm_ext  = 28'(bus.pcm_in);
      sum_nxt  = sum_p0 + pcm_ext;
      target   = bus.mute ? 9'd0 : (bus.low_batt ? 9'd128 : 9'd256);
      gain_nxt = gain_p1;
      if (tick_p0) begin
         if (gain_p1 < target)
            gain_nxt = gain_p1 + 9'd1;
         else if (gain_p1 > target)
            gain_nxt = gain_p1 - 9'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_p0    <= '0;
         sum_p0    <= '0;
         avg_p1    <= '0;
         gain_p1   <= '0;
         active_p1 <= 1'b0;
         vld_p1    <= 1'b0;
         audio_p2  <= '0;
         vld_p2    <= 1'b0;
      end else begin
         // p0 -> p1: rate generator, boxcar close-out and gain step
         acc_p0    <= 27'(tick_p0 ? acc_sum - CLK_C : acc_sum);
         sum_p0    <= tick_p0 ? '0 : sum_nxt;
         if (tick_p0)
            avg_p1 <= sat16(sum_nxt);
         gain_p1   <= gain_nxt;
         active_p1 <= (gain_nxt != 9'd0);
         vld_p1    <= tick_p0;
         // p1 -> p2: apply gain and publish
         vld_p2    <= vld_p1;
         if (vld_p1)
            audio_p2 <= scale(avg_p1, gain_p1);
      end
   end

   assign bus.audio_out  = audio_p2;
   assign bus.sample_stb = vld_p2;
   assign bus.active     = active_p1;

endmodule

// File: tb/tb_pcm_output_stage.sv
// Bench for pcm_output_stage: a fast-rate instance checked cycle by cycle against a reference
// model, plus a default-rate instance checked for strobe timing and reset behaviour.
module tb_pcm_output_stage;

   localparam longint CLK_S   = 1_000_000;
   localparam longint SAMP_S  = 48_000;
   localparam int     SHIFT_S = 4;

   logic clk       = 1'b0;
   logic reset     = 1'b1;
   logic reset_def = 1'b1;
   int   checks    = 0;
   int   failures  = 0;

   pcm_output_stage_if bus ();
   pcm_output_stage_if bus_def ();

   pcm_output_stage #(
      .CLK_HZ   (1_000_000),
      .SAMPLE_HZ(48_000),
      .SUM_SHIFT(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   pcm_output_stage dut_def (
      .clk  (clk),
      .reset(reset_def),
      .bus  (bus_def)
   );

   always #10 clk = ~clk;

   // Reference model state: cycles since reset, running sum, gain, queued published samples
   longint             m_n;
   longint             m_box;
   longint             m_gain;
   longint             m_due_q[$];
   longint             m_val_q[$];
   logic               exp_stb;
   logic               exp_active;
   logic signed [15:0] exp_out;

   task automatic step(input logic signed [15:0] pcm, input logic m, input logic lb,
                       input logic r);
      longint avg;
      longint tgt;
      @(negedge clk);
      bus.pcm_in   = pcm;
      bus.mute     = m;
      bus.low_batt = lb;
      reset        = r;
      @(posedge clk);
      if (r) begin
         m_n = 0; m_box = 0; m_gain = 0;
         exp_out = '0; exp_stb = 1'b0; exp_active = 1'b0;
         m_due_q.delete(); m_val_q.delete();
      end else begin
         exp_stb = 1'b0;
         if (m_due_q.size() > 0 && m_due_q[0] == m_n) begin
            exp_out = 16'(m_val_q.pop_front());
            void'(m_due_q.pop_front());
            exp_stb = 1'b1;
         end
         m_box += pcm;
         // A sample boundary falls wherever floor(n*SAMPLE/CLK) advances.
         if (((m_n + 1) * SAMP_S) / CLK_S != (m_n * SAMP_S) / CLK_S) begin
            avg = m_box >>> SHIFT_S;
            if (avg > 32767) avg = 32767;
            if (avg < -32768) avg = -32768;
            tgt = m ? 0 : (lb ? 128 : 256);
            if (m_gain < tgt) m_gain++;
            else if (m_gain > tgt) m_gain--;
            m_val_q.push_back((avg * m_gain) >>> 8);
            m_due_q.push_back(m_n + 1);
            m_box = 0;
         end
         exp_active = (m_gain != 0);
         m_n++;
      end
      #1;
   endtask

   task automatic test_reset();
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 200; c++) step(16'sd1000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.audio_out === 16'sd0 || bus.active !== 1'b1) begin
         failures++;
         $display("FAIL reset_prerun audio_out=%0d active=%b want nonzero/1", bus.audio_out, bus.active);
      end
      step(16'sd1000, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.audio_out !== 16'sd0) begin
         failures++; $display("FAIL reset_audio got=%0d want=0", bus.audio_out);
      end
      checks++;
      if (bus.sample_stb !== 1'b0) begin
         failures++; $display("FAIL reset_stb got=%b want=0", bus.sample_stb);
      end
      checks++;
      if (bus.active !== 1'b0) begin
         failures++; $display("FAIL reset_active got=%b want=0", bus.active);
      end
   endtask

   task automatic test_default_rate();
      int first;
      int gap;
      @(negedge clk) reset_def = 1'b1;
      @(negedge clk) reset_def = 1'b0;
      first = -1;
      for (int k = 0; k < 1200 && first < 0; k++) begin
         @(posedge clk); #1;
         if (bus_def.sample_stb) first = k + 1;
      end
      checks++;
      if (first != 1043) begin
         failures++; $display("FAIL default_first_stb cycle=%0d want=1043", first);
      end
      checks++;
      if (bus_def.audio_out !== 16'sd3) begin
         failures++; $display("FAIL default_first_value got=%0d want=3", bus_def.audio_out);
      end
      for (int i = 0; i < 3; i++) begin
         gap = 0;
         do begin
            @(posedge clk); #1; gap++;
         end while (!bus_def.sample_stb && gap < 1100);
         checks++;
         if (gap != 1041 && gap != 1042) begin
            failures++; $display("FAIL default_interval gap=%0d want=1041/1042", gap);
         end
      end
      // Reset while active clears every output
      @(negedge clk) reset_def = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_def.audio_out !== 16'sd0 || bus_def.sample_stb !== 1'b0 || bus_def.active !== 1'b0) begin
         failures++;
         $display("FAIL default_reset audio=%0d stb=%b active=%b want 0/0/0",
                  bus_def.audio_out, bus_def.sample_stb, bus_def.active);
      end
      @(negedge clk) reset_def = 1'b0;
      repeat (500) @(posedge clk);
      @(negedge clk) reset_def = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus_def.audio_out !== 16'sd0 || bus_def.sample_stb !== 1'b0 || bus_def.active !== 1'b0) begin
         failures++;
         $display("FAIL default_midreset audio=%0d stb=%b active=%b want 0/0/0",
                  bus_def.audio_out, bus_def.sample_stb, bus_def.active);
      end
      @(negedge clk) reset_def = 1'b0;
      first = -1;
      for (int k = 0; k < 1200 && first < 0; k++) begin
         @(posedge clk); #1;
         if (bus_def.sample_stb) first = k + 1;
      end
      checks++;
      if (first != 1043) begin
         failures++; $display("FAIL midreset_next_stb cycle=%0d want=1043", first);
      end
      checks++;
      if (bus_def.audio_out !== 16'sd3) begin
         failures++; $display("FAIL midreset_value got=%0d want=3 (partial sum kept?)", bus_def.audio_out);
      end
   endtask

   task automatic test_constant_ramp();
      int strobes = 0;
      logic signed [15:0] first_out = '0;
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 7000 && strobes < 300; c++) begin
         step(16'sd1000, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus.sample_stb !== exp_stb || bus.active !== exp_active) begin
            failures++;
            $display("FAIL ramp_ctrl cycle=%0d stb=%b want=%b active=%b want=%b",
                     m_n, bus.sample_stb, exp_stb, bus.active, exp_active);
         end
         if (exp_stb) begin
            strobes++;
            if (strobes == 1) first_out = bus.audio_out;
            checks++;
            if (bus.audio_out !== exp_out) begin
               failures++; $display("FAIL ramp_out strobe=%0d got=%0d want=%0d", strobes, bus.audio_out, exp_out);
            end
         end
      end
      checks++;
      if (first_out !== 16'sd5) begin
         failures++; $display("FAIL ramp_first got=%0d want=5", first_out);
      end
      checks++;
      if (bus.audio_out !== 16'sd1250 && bus.audio_out !== 16'sd1312) begin
         failures++; $display("FAIL ramp_full got=%0d want=1250/1312", bus.audio_out);
      end
   endtask

   task automatic test_saturation();
      int strobes = 0;
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 7000 && strobes < 270; c++) begin
         step(16'sh7fff, 1'b0, 1'b0, 1'b0);
         checks++;
         if (bus.sample_stb !== exp_stb || (exp_stb && bus.audio_out !== exp_out)) begin
            failures++;
            $display("FAIL sat_pos_track cycle=%0d stb=%b want=%b out=%0d want=%0d",
                     m_n, bus.sample_stb, exp_stb, bus.audio_out, exp_out);
         end
         if (exp_stb) strobes++;
      end
      checks++;
      if (bus.audio_out !== 16'sh7fff) begin
         failures++; $display("FAIL sat_pos got=%0d want=32767", bus.audio_out);
      end
      strobes = 0;
      for (int c = 0; c < 200 && strobes < 3; c++) begin
         step(16'sh8000, 1'b0, 1'b0, 1'b0);
         if (exp_stb) strobes++;
      end
      checks++;
      if (bus.audio_out !== 16'sh8000) begin
         failures++; $display("FAIL sat_neg got=%0d want=-32768", bus.audio_out);
      end
   endtask

   task automatic test_low_batt();
      int  strobes = 0;
      logic lb = 1'b0;
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 9000 && strobes < 400; c++) begin
         if (strobes >= 260) lb = 1'b1;
         step(16'sd1000, 1'b0, lb, 1'b0);
         checks++;
         if (bus.sample_stb !== exp_stb || bus.active !== exp_active) begin
            failures++;
            $display("FAIL lowbatt_ctrl cycle=%0d stb=%b want=%b active=%b want=%b",
                     m_n, bus.sample_stb, exp_stb, bus.active, exp_active);
         end
         if (exp_stb) begin
            strobes++;
            checks++;
            if (bus.audio_out !== exp_out) begin
               failures++; $display("FAIL lowbatt_out strobe=%0d got=%0d want=%0d", strobes, bus.audio_out, exp_out);
            end
         end
      end
      checks++;
      if (bus.audio_out !== 16'sd625 && bus.audio_out !== 16'sd656) begin
         failures++; $display("FAIL lowbatt_final got=%0d want=625/656", bus.audio_out);
      end
   endtask

   task automatic test_mute_reversal();
      int  strobes = 0;
      logic m = 1'b0;
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 5000 && strobes < 210; c++) begin
         if (strobes >= 100) m = 1'b1;
         step(16'($urandom_range(0, 20000)), m, 1'b0, 1'b0);
         checks++;
         if (bus.sample_stb !== exp_stb || bus.active !== exp_active) begin
            failures++;
            $display("FAIL mute_ctrl cycle=%0d stb=%b want=%b active=%b want=%b",
                     m_n, bus.sample_stb, exp_stb, bus.active, exp_active);
         end
         if (exp_stb) begin
            strobes++;
            checks++;
            if (bus.audio_out !== exp_out) begin
               failures++; $display("FAIL mute_out strobe=%0d got=%0d want=%0d", strobes, bus.audio_out, exp_out);
            end
         end
      end
      checks++;
      if (bus.audio_out !== 16'sd0 || bus.active !== 1'b0) begin
         failures++; $display("FAIL mute_final audio=%0d active=%b want 0/0", bus.audio_out, bus.active);
      end
   endtask

   task automatic test_random();
      logic m  = 1'b0;
      logic lb = 1'b0;
      step(16'sd0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) == 0) m = ~m;
         if ($urandom_range(0, 99) == 0) lb = ~lb;
         step(16'($urandom), m, lb, c == 1700);
         checks++;
         if (bus.sample_stb !== exp_stb || bus.active !== exp_active) begin
            failures++;
            $display("FAIL random_ctrl cycle=%0d stb=%b want=%b active=%b want=%b",
                     m_n, bus.sample_stb, exp_stb, bus.active, exp_active);
         end
         checks++;
         if (bus.audio_out !== exp_out) begin
            failures++; $display("FAIL random_out cycle=%0d got=%0d want=%0d", m_n, bus.audio_out, exp_out);
         end
      end
   endtask

   initial begin
      bus.pcm_in       = '0;
      bus.mute         = 1'b0;
      bus.low_batt     = 1'b0;
      bus_def.pcm_in   = 16'sd1000;
      bus_def.mute     = 1'b0;
      bus_def.low_batt = 1'b0;
      test_reset();
      test_default_rate();
      test_constant_ramp();
      test_saturation();
      test_low_batt();
      test_mute_reversal();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
